// File: rtl/sv32_shared_tlb_pkg.sv
// Types shared by the Sv32 second-level TLB: PTE layout, first-level refill
// record and the shared array entry.
package sv32_shared_tlb_pkg;

  localparam int ASID_MAX_W = 9;

  typedef struct packed {
    logic [21:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_sv32_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_4M;
    logic [19:0]           vpn;
    logic [ASID_MAX_W-1:0] asid;
    pte_sv32_t             content;
  } tlb_update_sv32_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_4M;
    logic [9:0]            vpn1;
    logic [9:0]            vpn0;
    logic [ASID_MAX_W-1:0] asid;
    pte_sv32_t             content;
  } shared_tlb_sv32_entry_t;

  function automatic tlb_update_sv32_t entry_to_update(shared_tlb_sv32_entry_t e);
    tlb_update_sv32_t u;
    u.valid   = e.valid;
    u.is_4M   = e.is_4M;
    u.vpn     = {e.vpn1, e.vpn0};
    u.asid    = e.asid;
    u.content = e.content;
    return u;
  endfunction

endpackage

// File: rtl/sv32_shared_tlb_lzc.sv
// Lowest-set-bit priority encoder; idx is 0 when the vector is empty.
module sv32_shared_tlb_lzc #(
  parameter int WIDTH = 16,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] idx,
  output logic             empty
);

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = CNT_W'(i);
    end
  end

  assign empty = ~|vec;

endmodule

// File: rtl/sv32_shared_tlb.sv
// Shared fully associative Sv32 L2 TLB: arbitrates ITLB/DTLB misses, refills
// them on a hit, otherwise defers to the PTW and captures its result.
module sv32_shared_tlb
  import sv32_shared_tlb_pkg::*;
#(
  parameter int NR_ENTRIES = 16,
  parameter int ASID_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  enable_translation_i,
  input  logic                  en_ld_st_translation_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  input  logic                  itlb_access_i,
  input  logic                  itlb_hit_i,
  input  logic [31:0]           itlb_vaddr_i,
  input  logic                  dtlb_access_i,
  input  logic                  dtlb_hit_i,
  input  logic [31:0]           dtlb_vaddr_i,
  output tlb_update_sv32_t      itlb_update_o,
  output tlb_update_sv32_t      dtlb_update_o,
  output logic                  shared_tlb_access_o,
  output logic                  shared_tlb_hit_o,
  output logic [31:0]           shared_tlb_vaddr_o,
  output logic                  itlb_req_o,
  input  tlb_update_sv32_t      shared_tlb_update_i,
  input  logic                  ptw_active_i,
  input  logic                  ptw_error_i,
  input  logic                  ptw_access_exception_i
);

  localparam int IDX_W = $clog2(NR_ENTRIES);

  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_PTW} state_e;

  state_e                 state_cur, state_nxt;
  logic [31:0]            vaddr_p0;
  logic [ASID_WIDTH-1:0]  asid_p0;
  logic                   is_instr_p0;
  shared_tlb_sv32_entry_t entries [NR_ENTRIES];
  shared_tlb_sv32_entry_t new_entry;
  tlb_update_sv32_t       hit_update;
  logic [IDX_W-1:0]       rr_ptr, hit_idx, free_idx, victim_idx;
  logic [NR_ENTRIES-1:0]  valid_vec, match_vec;
  logic                   no_hit, all_used;
  logic                   dtlb_miss, itlb_miss, take_req, write_en;

  // DTLB wins; the ITLB is only considered while the DTLB is not accessing at all.
  assign dtlb_miss = dtlb_access_i && !dtlb_hit_i && en_ld_st_translation_i;
  assign itlb_miss = itlb_access_i && !itlb_hit_i && enable_translation_i && !dtlb_access_i;
  assign take_req  = (state_cur == IDLE) && !flush_i && !ptw_active_i && (dtlb_miss || itlb_miss);
  assign write_en  = (state_cur == WAIT_PTW) && !flush_i && shared_tlb_update_i.valid;

  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) begin
      valid_vec[i] = entries[i].valid;
      match_vec[i] = entries[i].valid
                  && (entries[i].asid == ASID_MAX_W'(asid_p0) || entries[i].content.g)
                  && (entries[i].vpn1 == vaddr_p0[31:22])
                  && (entries[i].is_4M || entries[i].vpn0 == vaddr_p0[21:12]);
    end
  end

  sv32_shared_tlb_lzc #(.WIDTH(NR_ENTRIES)) u_hit_enc (
    .vec   (match_vec),
    .idx   (hit_idx),
    .empty (no_hit)
  );

  sv32_shared_tlb_lzc #(.WIDTH(NR_ENTRIES)) u_free_enc (
    .vec   (~valid_vec),
    .idx   (free_idx),
    .empty (all_used)
  );

  assign victim_idx = all_used ? rr_ptr : free_idx;
  assign hit_update = entry_to_update(entries[hit_idx]);

  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.is_4M   = shared_tlb_update_i.is_4M;
    new_entry.vpn1    = shared_tlb_update_i.vpn[19:10];
    new_entry.vpn0    = shared_tlb_update_i.vpn[9:0];
    new_entry.asid    = ASID_MAX_W'(shared_tlb_update_i.asid[ASID_WIDTH-1:0]);
    new_entry.content = shared_tlb_update_i.content;
  end

  // Stage p0: request capture and control state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_cur   <= IDLE;
      rr_ptr      <= '0;
      is_instr_p0 <= 1'b0;
    end else begin
      state_cur <= state_nxt;
      if (take_req) is_instr_p0 <= !dtlb_miss;
      if (write_en) rr_ptr <= rr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (take_req) begin
      vaddr_p0 <= dtlb_miss ? dtlb_vaddr_i : itlb_vaddr_i;
      asid_p0  <= asid_i;
    end
  end

  // Only valid bits are reset; payload is don't-care while invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) entries[i].valid <= 1'b0;
    end else if (write_en) begin
      entries[victim_idx] <= new_entry;
    end
  end

  always_comb begin
    state_nxt = state_cur;
    case (state_cur)
      IDLE:     if (take_req) state_nxt = LOOKUP;
      LOOKUP:   state_nxt = (flush_i || !no_hit) ? IDLE : WAIT_PTW;
      WAIT_PTW: if (flush_i || shared_tlb_update_i.valid || ptw_error_i || ptw_access_exception_i)
                  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    itlb_update_o       = '0;
    dtlb_update_o       = '0;
    shared_tlb_access_o = 1'b0;
    shared_tlb_hit_o    = 1'b0;
    shared_tlb_vaddr_o  = '0;
    itlb_req_o          = 1'b0;
    if (!flush_i) begin
      case (state_cur)
        LOOKUP: begin
          shared_tlb_access_o = 1'b1;
          shared_tlb_vaddr_o  = vaddr_p0;
          itlb_req_o          = is_instr_p0;
          shared_tlb_hit_o    = !no_hit;
          if (!no_hit) begin
            if (is_instr_p0) itlb_update_o = hit_update;
            else             dtlb_update_o = hit_update;
          end
        end
        WAIT_PTW: begin
          if (shared_tlb_update_i.valid) begin
            if (is_instr_p0) itlb_update_o = shared_tlb_update_i;
            else             dtlb_update_o = shared_tlb_update_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sv32_shared_tlb.sv
// Randomized and directed bench for sv32_shared_tlb against an array-based
// model of the shared TLB contents and replacement policy.
module tb_sv32_shared_tlb;
  import sv32_shared_tlb_pkg::*;

  localparam int N = 16;

  logic             clk = 1'b0;
  logic             rst, flush, en_tr, en_ls, asid;
  logic             itlb_access, itlb_hit, dtlb_access, dtlb_hit;
  logic [31:0]      itlb_vaddr, dtlb_vaddr, vaddr;
  tlb_update_sv32_t itlb_upd, dtlb_upd, ptw_upd;
  logic             access, hit, itlb_req;
  logic             ptw_active, ptw_error, ptw_exc;

  int checks = 0;
  int errors = 0;

  sv32_shared_tlb #(.NR_ENTRIES(N), .ASID_WIDTH(1)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .flush_i                (flush),
    .enable_translation_i   (en_tr),
    .en_ld_st_translation_i (en_ls),
    .asid_i                 (asid),
    .itlb_access_i          (itlb_access),
    .itlb_hit_i             (itlb_hit),
    .itlb_vaddr_i           (itlb_vaddr),
    .dtlb_access_i          (dtlb_access),
    .dtlb_hit_i             (dtlb_hit),
    .dtlb_vaddr_i           (dtlb_vaddr),
    .itlb_update_o          (itlb_upd),
    .dtlb_update_o          (dtlb_upd),
    .shared_tlb_access_o    (access),
    .shared_tlb_hit_o       (hit),
    .shared_tlb_vaddr_o     (vaddr),
    .itlb_req_o             (itlb_req),
    .shared_tlb_update_i    (ptw_upd),
    .ptw_active_i           (ptw_active),
    .ptw_error_i            (ptw_error),
    .ptw_access_exception_i (ptw_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: page records in slot order plus a replacement pointer.
  bit               m_valid [N];
  tlb_update_sv32_t m_ent   [N];
  int               m_ptr;

  function automatic int m_lookup(logic [31:0] va, logic a);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && (m_ent[i].asid == {8'b0, a} || m_ent[i].content.g)
          && m_ent[i].vpn[19:10] == va[31:22]
          && (m_ent[i].is_4M || m_ent[i].vpn[9:0] == va[21:12]))
        return i;
    return -1;
  endfunction

  function automatic tlb_update_sv32_t m_expect(logic [31:0] va, logic a);
    int idx;
    idx = m_lookup(va, a);
    if (idx < 0) return '0;
    return m_ent[idx];
  endfunction

  function automatic void m_insert(tlb_update_sv32_t u);
    int v;
    v = -1;
    for (int i = 0; i < N; i++) if (!m_valid[i] && v < 0) v = i;
    if (v < 0) v = m_ptr;
    m_ptr      = (m_ptr + 1) % N;
    m_valid[v] = 1'b1;
    m_ent[v]   = u;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic tlb_update_sv32_t sel(bit c, tlb_update_sv32_t u);
    return c ? u : '0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; en_tr = 1'b1; en_ls = 1'b1; asid = 1'b0;
    itlb_access = 1'b0; itlb_hit = 1'b0; itlb_vaddr = '0;
    dtlb_access = 1'b0; dtlb_hit = 1'b0; dtlb_vaddr = '0;
    ptw_upd = '0; ptw_active = 1'b0; ptw_error = 1'b0; ptw_exc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_clear();
    m_ptr = 0;
  endtask

  // mode 0: PTW answers, 1: PTW error, 2: flush coincident with PTW answer
  task automatic req(input bit instr, input logic [31:0] va, input logic a, input int mode,
                     input bit is4m, input bit g, output bit got_hit);
    int idx;
    tlb_update_sv32_t exp_u, upd;
    @(negedge clk);
    asid = a;
    if (instr) begin itlb_access = 1'b1; itlb_hit = 1'b0; itlb_vaddr = va; end
    else       begin dtlb_access = 1'b1; dtlb_hit = 1'b0; dtlb_vaddr = va; end
    @(negedge clk);
    itlb_access = 1'b0;
    dtlb_access = 1'b0;
    #1;
    idx     = m_lookup(va, a);
    exp_u   = m_expect(va, a);
    got_hit = hit;
    chk("lk_access", 64'(access), 64'(1'b1));
    chk("lk_vaddr", 64'(vaddr), 64'(va));
    chk("lk_itlb_req", 64'(itlb_req), 64'(instr));
    chk("lk_hit", 64'(hit), 64'(idx >= 0));
    chk("lk_itlb_upd", 64'(itlb_upd), 64'(sel(instr, exp_u)));
    chk("lk_dtlb_upd", 64'(dtlb_upd), 64'(sel(!instr, exp_u)));
    if (idx < 0) begin
      upd = '0;
      upd.valid = 1'b1;
      upd.is_4M = is4m;
      upd.vpn = va[31:12];
      upd.asid = {8'b0, a};
      upd.content.ppn = 22'($urandom);
      upd.content.v = 1'b1;
      upd.content.r = 1'b1;
      upd.content.a = 1'b1;
      upd.content.g = g;
      @(negedge clk);
      ptw_active = 1'b1;
      #1;
      chk("wait_no_access", 64'(access), 64'(1'b0));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        #1;
        chk("wait_quiet", 64'({itlb_upd.valid, dtlb_upd.valid, access}), 64'(0));
      end
      case (mode)
        0: begin
          ptw_upd = upd;
          #1;
          chk("fwd_itlb", 64'(itlb_upd), 64'(sel(instr, upd)));
          chk("fwd_dtlb", 64'(dtlb_upd), 64'(sel(!instr, upd)));
          m_insert(upd);
        end
        1: begin
          if ($urandom_range(0, 1) == 0) ptw_error = 1'b1;
          else                           ptw_exc   = 1'b1;
          #1;
          chk("err_no_upd", 64'({itlb_upd.valid, dtlb_upd.valid}), 64'(0));
        end
        default: begin
          ptw_upd = upd;
          flush   = 1'b1;
          #1;
          chk("flush_no_upd", 64'({itlb_upd.valid, dtlb_upd.valid, access}), 64'(0));
          m_clear();
        end
      endcase
      @(negedge clk);
      ptw_upd = '0; ptw_error = 1'b0; ptw_exc = 1'b0; flush = 1'b0; ptw_active = 1'b0;
      #1;
      chk("back_idle", 64'({access, itlb_upd.valid, dtlb_upd.valid}), 64'(0));
    end
  endtask

  initial begin
    bit h;
    do_reset();
    #1;
    chk("rst_access", 64'(access), 64'(0));
    chk("rst_hit", 64'(hit), 64'(0));
    chk("rst_vaddr", 64'(vaddr), 64'(0));
    chk("rst_itlb_req", 64'(itlb_req), 64'(0));
    chk("rst_itlb_upd", 64'(itlb_upd), 64'(0));
    chk("rst_dtlb_upd", 64'(dtlb_upd), 64'(0));

    // cold miss, then repeat hits
    req(1'b0, 32'h8000_1234, 1'b0, 0, 1'b0, 1'b0, h);
    chk("cold_miss", 64'(h), 64'(0));
    req(1'b0, 32'h8000_1234, 1'b0, 0, 1'b0, 1'b0, h);
    chk("cold_rehit", 64'(h), 64'(1));

    // 4M global page and ASID isolation
    req(1'b0, 32'h8000_0000, 1'b0, 0, 1'b1, 1'b1, h);
    chk("mega_fill", 64'(h), 64'(0));
    req(1'b0, 32'h803F_F000, 1'b0, 0, 1'b0, 1'b0, h);
    chk("mega_top_hit", 64'(h), 64'(1));
    req(1'b0, 32'h8000_0000, 1'b1, 0, 1'b0, 1'b0, h);
    chk("mega_global_hit", 64'(h), 64'(1));
    req(1'b0, 32'h1234_5000, 1'b0, 0, 1'b0, 1'b0, h);
    req(1'b0, 32'h1234_5000, 1'b1, 1, 1'b0, 1'b0, h);
    chk("asid_isolation", 64'(h), 64'(0));

    // simultaneous ITLB and DTLB miss
    @(negedge clk);
    asid = 1'b0;
    itlb_access = 1'b1; itlb_hit = 1'b0; itlb_vaddr = 32'h803F_F000;
    dtlb_access = 1'b1; dtlb_hit = 1'b0; dtlb_vaddr = 32'h8000_1234;
    @(negedge clk);
    dtlb_access = 1'b0;
    #1;
    chk("both_d_itlb_req", 64'(itlb_req), 64'(0));
    chk("both_d_vaddr", 64'(vaddr), 64'(32'h8000_1234));
    chk("both_d_hit", 64'(hit), 64'(1));
    chk("both_d_upd", 64'(dtlb_upd), 64'(m_expect(32'h8000_1234, 1'b0)));
    @(negedge clk);
    #1;
    chk("both_gap_access", 64'(access), 64'(0));
    @(negedge clk);
    itlb_access = 1'b0;
    #1;
    chk("both_i_itlb_req", 64'(itlb_req), 64'(1));
    chk("both_i_vaddr", 64'(vaddr), 64'(32'h803F_F000));
    chk("both_i_upd", 64'(itlb_upd), 64'(m_expect(32'h803F_F000, 1'b0)));
    chk("both_i_dtlb_quiet", 64'(dtlb_upd), 64'(0));

    // requests that must be ignored
    @(negedge clk);
    dtlb_access = 1'b1; dtlb_hit = 1'b1; dtlb_vaddr = 32'h0000_5000;
    itlb_access = 1'b1; itlb_hit = 1'b0; itlb_vaddr = 32'h0000_6000;
    @(negedge clk);
    dtlb_access = 1'b0; dtlb_hit = 1'b0; itlb_access = 1'b0;
    #1;
    chk("ign_l1_hit_blocks_itlb", 64'(access), 64'(0));
    @(negedge clk);
    dtlb_access = 1'b1; en_ls = 1'b0;
    @(negedge clk);
    dtlb_access = 1'b0; en_ls = 1'b1;
    #1;
    chk("ign_ls_disabled", 64'(access), 64'(0));
    @(negedge clk);
    itlb_access = 1'b1; en_tr = 1'b0;
    @(negedge clk);
    itlb_access = 1'b0; en_tr = 1'b1;
    #1;
    chk("ign_tr_disabled", 64'(access), 64'(0));

    // flush with coincident PTW update, then PTW drain blocks arbitration
    req(1'b0, 32'h5555_5000, 1'b0, 2, 1'b0, 1'b0, h);
    @(negedge clk);
    ptw_active = 1'b1;
    dtlb_access = 1'b1; dtlb_hit = 1'b0; dtlb_vaddr = 32'h8000_1234;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("drain_no_access", 64'(access), 64'(0));
    end
    @(negedge clk);
    dtlb_access = 1'b0; ptw_active = 1'b0;
    req(1'b0, 32'h8000_1234, 1'b0, 1, 1'b0, 1'b0, h);
    chk("flush_cleared_page", 64'(h), 64'(0));
    req(1'b1, 32'h803F_F000, 1'b0, 1, 1'b0, 1'b0, h);
    chk("flush_cleared_mega", 64'(h), 64'(0));

    // PTW error leaves the array untouched
    req(1'b0, 32'h6666_6000, 1'b0, 1, 1'b0, 1'b0, h);
    req(1'b0, 32'h6666_6000, 1'b0, 1, 1'b0, 1'b0, h);
    chk("err_not_written", 64'(h), 64'(0));

    // replacement after filling every slot from reset
    do_reset();
    for (int p = 0; p < N + 1; p++) begin
      req(1'b0, 32'h4000_0000 + (p << 12), 1'b0, 0, 1'b0, 1'b0, h);
      chk("fill_cold", 64'(h), 64'(0));
    end
    req(1'b0, 32'h4000_0000, 1'b0, 1, 1'b0, 1'b0, h);
    chk("fill_first_evicted", 64'(h), 64'(0));
    req(1'b0, 32'h4000_1000, 1'b0, 1, 1'b0, 1'b0, h);
    chk("fill_second_kept", 64'(h), 64'(1));
    req(1'b0, 32'h4001_0000, 1'b0, 1, 1'b0, 1'b0, h);
    chk("fill_last_present", 64'(h), 64'(1));

    // randomized traffic over a small page pool
    for (int k = 0; k < 200; k++) begin
      int j, r, md;
      logic [31:0] va;
      j  = $urandom_range(0, 23);
      va = {10'(10'h100 + j / 8), 10'(j % 8), 12'($urandom)};
      r  = $urandom_range(0, 15);
      md = (r == 0) ? 2 : ((r < 3) ? 1 : 0);
      req(1'($urandom_range(0, 1)), va, 1'($urandom_range(0, 1)), md,
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
